// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the moving-average filter.
// Provides the running-sum width and window-length helpers used by all files.
package moving_average_pkg;

    // Width of the running sum: WIN samples of DATA_W bits never overflow it.
    function automatic int sum_width(input int data_w, input int log2_win);
        return data_w + log2_win;
    endfunction

    // Number of samples in the averaging window.
    function automatic int win_len(input int log2_win);
        return 1 << log2_win;
    endfunction

endpackage

// File: rtl/moving_average_if.sv
// Sample stream bundle between a data source and the moving-average filter.
// Ports: in_valid/in_data (source side), out_valid/out_data/out_sum/primed (filter side).
interface moving_average_if
    import moving_average_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
);
    localparam int SW = sum_width(DATA_W, LOG2_WIN);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SW-1:0]     out_sum;
    logic              primed;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_sum, primed
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_sum, primed
    );
endinterface

// File: rtl/sample_ring.sv
// WIN-deep delay line holding the most recent accepted samples.
// Ports: clock, reset, wr_en, wr_data in; rd_old (entry under wptr, pre-write), full out.
module sample_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_old,
    output logic              full
);
    localparam int WIN = win_len(LOG2_WIN);
    localparam logic [LOG2_WIN:0] WIN_C = {1'b1, {LOG2_WIN{1'b0}}};

    logic [DATA_W-1:0]   mem [WIN];
    logic [LOG2_WIN-1:0] wptr;
    logic [LOG2_WIN:0]   count;

    // The slot about to be overwritten holds the sample leaving the window.
    assign rd_old = mem[wptr];
    assign full   = (count == WIN_C);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            count <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Contents need no reset: count gates every read until slots are written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end
endmodule

// File: rtl/moving_average.sv
// Streaming boxcar filter: running sum and floor mean of the last 2^LOG2_WIN samples.
// Ports: clock, reset, clear; bus (slave) carries the sample stream and filtered outputs.
module moving_average
    import moving_average_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3,
    parameter int SIGNED   = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    moving_average_if.slave bus
);
    localparam int SW = sum_width(DATA_W, LOG2_WIN);

    logic              accept;
    logic              ring_rst;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] oldest;
    logic              full;
    logic [SW-1:0]     in_ext;
    logic [SW-1:0]     old_ext;
    logic [SW-1:0]     sum;
    logic [SW-1:0]     sum_next;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [SW-1:0]     sum_q;

    // clear beats a coincident sample, which is dropped.
    assign accept   = bus.in_valid & ~clear;
    assign ring_rst = reset | clear;

    sample_ring #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_ring (
        .clock   (clock),
        .reset   (ring_rst),
        .wr_en   (accept),
        .wr_data (bus.in_data),
        .rd_old  (rd_old),
        .full    (full)
    );

    // During warm-up the missing samples count as zero.
    assign oldest = full ? rd_old : '0;

    always_comb begin
        if (SIGNED != 0) begin
            in_ext  = {{LOG2_WIN{bus.in_data[DATA_W-1]}}, bus.in_data};
            old_ext = {{LOG2_WIN{oldest[DATA_W-1]}}, oldest};
        end else begin
            in_ext  = {{LOG2_WIN{1'b0}}, bus.in_data};
            old_ext = {{LOG2_WIN{1'b0}}, oldest};
        end
        sum_next = sum + in_ext - old_ext;
    end

    // Dropping the low LOG2_WIN bits is a floor divide for both encodings.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sum_q   <= '0;
        end else if (clear) begin
            sum     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                sum    <= sum_next;
                sum_q  <= sum_next;
                data_q <= sum_next[SW-1:LOG2_WIN];
            end
        end
    end

    // The ring fills on the same edge that registers the WIN-th result.
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sum   = sum_q;
    assign bus.primed    = full;
endmodule

// File: tb/tb_moving_average.sv
// Self-checking bench: unsigned and signed filters (window 4) against a queue model.
// Directed vectors with literal expectations also pin the model.
module tb_moving_average;
    localparam int DW = 8;
    localparam int LW = 2;
    localparam int WIN = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    bit   chk_en = 1'b0;

    int compared = 0;
    int mismatched = 0;

    moving_average_if #(.DATA_W(DW), .LOG2_WIN(LW)) ifu ();
    moving_average_if #(.DATA_W(DW), .LOG2_WIN(LW)) ifs ();

    moving_average #(.DATA_W(DW), .LOG2_WIN(LW), .SIGNED(0)) u_dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (ifu.slave)
    );

    moving_average #(.DATA_W(DW), .LOG2_WIN(LW), .SIGNED(1)) s_dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (ifs.slave)
    );

    always #5 clock = ~clock;

    // Model: the window is simply the last WIN accepted values; absent ones are zero.
    int hu[$];
    int hs[$];
    int eu_valid = 0, eu_sum = 0, eu_data = 0, eu_primed = 0;
    int es_valid = 0, es_sum = 0, es_data = 0, es_primed = 0;

    always @(posedge clock) begin
        int s;
        if (reset) begin
            hu.delete();
            eu_valid <= 0; eu_sum <= 0; eu_data <= 0; eu_primed <= 0;
        end else if (clear) begin
            hu.delete();
            eu_valid <= 0; eu_primed <= 0;
        end else if (ifu.in_valid) begin
            hu.push_back(int'(ifu.in_data));
            if (hu.size() > WIN) void'(hu.pop_front());
            s = 0;
            foreach (hu[i]) s += hu[i];
            eu_valid <= 1; eu_sum <= s; eu_data <= s >>> LW;
            eu_primed <= (hu.size() == WIN) ? 1 : 0;
        end else begin
            eu_valid <= 0;
        end
    end

    always @(posedge clock) begin
        int s;
        if (reset) begin
            hs.delete();
            es_valid <= 0; es_sum <= 0; es_data <= 0; es_primed <= 0;
        end else if (clear) begin
            hs.delete();
            es_valid <= 0; es_primed <= 0;
        end else if (ifs.in_valid) begin
            hs.push_back(int'($signed(ifs.in_data)));
            if (hs.size() > WIN) void'(hs.pop_front());
            s = 0;
            foreach (hs[i]) s += hs[i];
            es_valid <= 1; es_sum <= s; es_data <= s >>> LW;
            es_primed <= (hs.size() == WIN) ? 1 : 0;
        end else begin
            es_valid <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int u_sum();
        return int'(ifu.out_sum);
    endfunction

    function automatic int u_data();
        return int'(ifu.out_data);
    endfunction

    function automatic int s_sum();
        return int'($signed(ifs.out_sum));
    endfunction

    function automatic int s_data();
        return int'($signed(ifs.out_data));
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("u_valid",  int'(ifu.out_valid), eu_valid);
            chk("u_sum",    u_sum(),             eu_sum);
            chk("u_data",   u_data(),            eu_data);
            chk("u_primed", int'(ifu.primed),    eu_primed);
            chk("s_valid",  int'(ifs.out_valid), es_valid);
            chk("s_sum",    s_sum(),             es_sum);
            chk("s_data",   s_data(),            es_data);
            chk("s_primed", int'(ifs.primed),    es_primed);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lit_u(input string n, input int v, input int sm, input int d, input int p);
        chk({n, "_valid"},  int'(ifu.out_valid), v);
        chk({n, "_sum"},    u_sum(),             sm);
        chk({n, "_data"},   u_data(),            d);
        chk({n, "_primed"}, int'(ifu.primed),    p);
    endtask

    task automatic push_u(input int v);
        ifu.in_valid = 1'b1;
        ifu.in_data  = v[DW-1:0];
        step();
        ifu.in_valid = 1'b0;
    endtask

    task automatic push_s(input int v);
        ifs.in_valid = 1'b1;
        ifs.in_data  = v[DW-1:0];
        step();
        ifs.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int seq_in[5]  = '{42, 59, 7, 20, 100};
    int seq_sum[5] = '{42, 101, 108, 128, 186};
    int seq_dat[5] = '{10, 25, 27, 32, 46};
    int seq_pr[5]  = '{0, 0, 0, 1, 1};
    int sat_sum[6] = '{255, 510, 765, 1020, 1020, 1020};
    int sat_dat[6] = '{63, 127, 191, 255, 255, 255};

    initial begin
        ifu.in_valid = 1'b0; ifu.in_data = '0;
        ifs.in_valid = 1'b0; ifs.in_data = '0;
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        lit_u("rst", 0, 0, 0, 0);

        foreach (seq_in[i]) begin
            push_u(seq_in[i]);
            lit_u($sformatf("seq%0d", i), 1, seq_sum[i], seq_dat[i], seq_pr[i]);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_u(255);
            lit_u($sformatf("sat%0d", i), 1, sat_sum[i], sat_dat[i], (i >= 3) ? 1 : 0);
        end

        do_reset();
        push_s(-1);
        chk("sgn1_sum", s_sum(), -1);
        chk("sgn1_data", s_data(), -1);
        for (int i = 0; i < 3; i++) push_s(-3);
        chk("sgn4_sum", s_sum(), -10);
        chk("sgn4_data", s_data(), -3);
        chk("sgn4_primed", int'(ifs.primed), 1);

        do_reset();
        push_u(10);
        lit_u("gap0", 1, 10, 2, 0);
        step();
        lit_u("gap1", 0, 10, 2, 0);
        step();
        lit_u("gap2", 0, 10, 2, 0);
        push_u(30);
        lit_u("gap3", 1, 40, 10, 0);

        do_reset();
        for (int i = 0; i < 4; i++) push_u(4);
        lit_u("prime", 1, 16, 4, 1);
        clear = 1'b1;
        ifu.in_valid = 1'b1;
        ifu.in_data = 8'd200;
        step();
        clear = 1'b0;
        ifu.in_valid = 1'b0;
        lit_u("clr", 0, 16, 4, 0);
        push_u(8);
        lit_u("clr_next", 1, 8, 2, 0);

        do_reset();
        push_u(50);
        push_u(60);
        push_u(70);
        do_reset();
        lit_u("mid_rst", 0, 0, 0, 0);
        push_u(40);
        lit_u("mid_next", 1, 40, 10, 0);

        step();
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/moving_average.md
Name: moving_average

Overview:
- Streaming boxcar (moving-average) filter over the last 2^LOG2_WIN accepted samples.
- Keeps a running sum updated incrementally: add the new sample, subtract the sample leaving the window.
- Replaces one-shot averaging of a fixed sample array with a per-sample pipelined result.
- Sits between a sampled data source (sensor/ADC/pixel stream) and downstream consumers of smoothed data.

Parameters:
- DATA_W, 8, width of input and averaged output samples.
- LOG2_WIN, 3, log2 of window length; WIN = 2^LOG2_WIN, legal range 1..8.
- SIGNED, 0, 0 = unsigned samples; 1 = two's-complement samples with arithmetic shift.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of window state; outputs keep their last values.
- in_valid  input  1  in_data is accepted this cycle. No backpressure: always accepted.
- in_data  input  DATA_W  input sample.
- out_valid  output  1  one-cycle pulse; out_data/out_sum updated.
- out_data  output  DATA_W  windowed mean: out_sum >>> LOG2_WIN (floor).
- out_sum  output  DATA_W+LOG2_WIN  full running sum of the window.
- primed  output  1  window holds WIN real samples since last reset/clear.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sum=0, primed=0. Internal sum, wptr and count are zeroed. Ring contents are don't-care.
- State:
  - ring[WIN] of DATA_W.
  - wptr (LOG2_WIN bits), wraps WIN-1 -> 0 naturally.
  - count (LOG2_WIN+1 bits), saturates at WIN.
  - sum (DATA_W+LOG2_WIN bits).
- Accept (in_valid=1, clear=0):
  - oldest = ring[wptr] if count==WIN, else 0. The ring is read before it is written in the same cycle.
  - sum <= sum + ext(in_data) - ext(oldest). ext is sign- or zero-extension per SIGNED.
  - ring[wptr] <= in_data; wptr <= wptr+1; count <= min(count+1, WIN).
- Latency:
  - out_valid pulses exactly 1 cycle after each accepted sample.
  - out_sum shows the updated sum in that cycle; out_data = updated sum >>> LOG2_WIN.
  - Back-to-back in_valid gives back-to-back out_valid.
- Warm-up: before primed, the missing samples count as zero, so out_data = partial_sum/WIN. This is not partial_sum/count.
- primed: goes to 1 in the same cycle as the out_valid for the WIN-th sample. Stays 1 until reset or clear.
- Idle (in_valid=0): out_valid=0; out_data, out_sum and primed hold.
- Overflow: the sum width is sized so it cannot overflow. out_data always fits DATA_W: the mean of representable values is representable.
- Rounding: floor toward -inf, for both signed and unsigned.
- clear:
  - Next cycle: sum=0, count=0, wptr=0, primed=0, out_valid=0.
  - out_data and out_sum hold their previous values.
  - clear together with in_valid: clear wins and the sample is dropped.
- Reset mid-stream: same as initial reset. The next accepted sample starts a fresh window.

Decomposition:
- Package moving_average_pkg:
  - function sum_width(DATA_W, LOG2_WIN) = DATA_W+LOG2_WIN.
  - localparam-style helper for WIN.
- Sub-module sample_ring: WIN x DATA_W delay line.
  - Ports: clock, reset, wr_en, wr_data, rd_old.
  - rd_old returns the entry at the current write pointer, read-before-write.
  - Owns wptr and count, and exposes full.
- The top level owns the sum arithmetic, the output registers and clear.

Test Plan:
- DATA_W=8, LOG2_WIN=2, unsigned; feed 42,59,7,20,100 back-to-back.
  - out_sum = 42,101,108,128,186.
  - out_data = 10,25,27,32,46.
  - primed = 0,0,0,1,1.
- Same config; feed 255 six times.
  - out_sum = 255,510,765,1020,1020,1020.
  - out_data = 63,127,191,255,255,255; no wrap.
- SIGNED=1, DATA_W=8, LOG2_WIN=2:
  - Feed -1: out_sum=-1, out_data=-1 (floor).
  - Then -3,-3,-3: out_sum=-10, out_data=-3 (floor of -2.5); primed=1.
- Gapped input: 10, 2 idle cycles, 30.
  - out_valid pulses only on the cycle after each sample.
  - out_data stays 2 through the idle cycles, then 10 (sum 40).
- Window of 4 primed with 4,4,4,4.
  - Assert clear together with in_valid=200: the sample is dropped; primed=0; out_data holds 4.
  - Then feed 8: out_sum=8, out_data=2.
- Reset asserted mid-stream after 3 samples: all outputs 0. Feeding 40 then gives out_sum=40, out_data=10, primed=0.
